// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// A PC register drives instruction memory directly. Each returned word is
// captured with its PC into a 2-entry FIFO, and decode drains the FIFO head
// through a valid/ready handshake. A redirect flushes the FIFO and reloads the PC.
// A fetch reaches the outputs one cycle after it is captured. Nothing is
// bypassed from imem_data straight to the outputs.

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_ins
);

    localparam logic [1:0] CNT_FULL = 2'd2;

    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] buf_pc_q  [2];
    logic [31:0] buf_ins_q [2];

    logic        push;
    logic        pop;

    // Handshake terms. A redirect masks out_valid, so it also suppresses pop
    assign out_valid = (cnt_q != 2'd0) & ~redirect;
    assign pop       = out_valid & out_ready;
    assign push      = ~redirect & ((cnt_q != CNT_FULL) | pop);

    assign imem_addr = pc_q;
    assign out_pc    = buf_pc_q[rd_ptr_q];
    assign out_ins   = buf_ins_q[rd_ptr_q];

    // Next-state logic for the PC, the occupancy count and the FIFO pointers
    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect) begin
            // Drop everything buffered. Force word alignment of the new target
            pc_d     = {redirect_pc[31:2], 2'b00};
            cnt_d    = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage. Entries are only ever read while count is nonzero, so the
    // contents are not reset
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]  <= pc_q;
            buf_ins_q[wr_ptr_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// Inputs change on the falling edge, and the outputs are checked 1 ns later.

module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_ins     (out_ins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h00A0_0093;
        else if (a == 32'h4) return 32'h0040_0113;
        else                 return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic [31:0] rp, input logic rdy,
                                input logic v, input logic [31:0] p, input logic [31:0] a);
        vec_t t;
        t.redir = r; t.rpc = rp; t.ready = rdy;
        t.exp_valid = v; t.exp_pc = p; t.exp_addr = a;
        return t;
    endfunction

    initial begin
        //             redir rpc           rdy valid pc            addr
        vecs[0]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0);
        vecs[1]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h4);
        vecs[2]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h8);
        vecs[3]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'hC);
        vecs[4]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h10);
        vecs[5]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h10);
        vecs[6]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h10);
        vecs[7]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h14);
        vecs[8]  = mk(1'b1, 32'h13,       1'b1, 1'b0, 32'h0,        32'h18);
        vecs[9]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h10);
        vecs[10] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       32'h14);
        vecs[11] = mk(1'b1, 32'h100,      1'b1, 1'b0, 32'h0,        32'h18);
        vecs[12] = mk(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0,       32'h100);
        vecs[13] = mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'hFFFF_FFFC);
        vecs[14] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0);
        vecs[15] = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h4);
        vecs[16] = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8);

        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b1;
        #1;
        check("reset_valid", {31'b0, out_valid}, 32'h0);
        check("reset_addr", imem_addr, 32'h0);

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            out_ready   = vecs[i].ready;
            #1;
            check($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_pc", i), out_pc, vecs[i].exp_pc);
                check($sformatf("v%0d_ins", i), out_ins, mem_word(vecs[i].exp_pc));
            end
            @(negedge clk);
        end

        // FIFO is full (PCs 0 and 4). Assert reset between edges and check that it acts at once
        redirect  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'h0);
        check("async_rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("hold_rst_addr", imem_addr, 32'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_valid0", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        #1;
        // Buffered entries from before the reset must be gone
        check("post_rst_valid1", {31'b0, out_valid}, 32'h1);
        check("post_rst_pc", out_pc, 32'h0);
        check("post_rst_ins", out_ins, 32'h00A0_0093);
        check("post_rst_addr", imem_addr, 32'h4);
        @(negedge clk);
        #1;
        check("post_rst_pc2", out_pc, 32'h4);
        check("post_rst_ins2", out_ins, 32'h0040_0113);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_addr  output  32  byte address to instruction memory; always equals the PC register.
REQ-005 imem_data  input  32  instruction word returned combinationally by instruction memory for imem_addr (little-endian byte order already applied).
REQ-006 redirect  input  1  downstream request to abandon sequential fetch.
REQ-007 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-008 out_valid  output  1  head entry of the fetch buffer is presented to decode.
REQ-009 out_ready  input  1  decode accepts the presented entry.
REQ-010 out_pc  output  32  byte address of the presented instruction.
REQ-011 out_ins  output  32  presented instruction word.

Function
REQ-012 The block SHALL hold a 32-bit PC register and a 2-entry FIFO of {pc, ins} pairs with a 2-bit occupancy count (0..2).
REQ-013 imem_addr SHALL be driven directly from the PC register; no read latency beyond the combinational memory path.
REQ-014 pop = out_valid & out_ready; push = ~redirect & (count<2 | pop).
REQ-015 On push, {PC, imem_data} SHALL be written at the FIFO tail and PC SHALL become PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-016 With no push and no redirect, PC SHALL hold its value.
REQ-017 Full with no pop: no push, PC unchanged, imem_data ignored.
REQ-018 Full with pop in the same cycle: push and pop both occur, count stays 2, order preserved.
REQ-019 Empty: out_valid=0; out_pc/out_ins are don't-care; the same-cycle push SHALL NOT be bypassed to outputs (minimum fetch-to-decode latency is 1 cycle).
REQ-020 out_valid = (count!=0) & ~redirect; out_pc/out_ins SHALL come from the FIFO head register, not from imem_data.
REQ-021 redirect=1 SHALL, at the next edge, set count to 0, set PC to {redirect_pc[31:2], 2'b00}, and discard any push or pop that cycle.
REQ-022 The cycle after a redirect, the fetch from the new PC SHALL proceed normally; its instruction appears on outputs one cycle later (redirect-to-out_valid = 2 cycles).
REQ-023 Back-to-back redirects: the last one wins; no entry from an abandoned path SHALL ever reach out_valid=1.
REQ-024 Entries SHALL leave in strict fetch order; each fetched PC appears on out_pc exactly once unless flushed.

Reset
REQ-025 While rst_n=0: PC=RESET_PC, count=0, out_valid=0, FIFO pointers=0; effect immediate (asynchronous).
REQ-026 Reset deassertion SHALL be recognised only at a clk rising edge; the first push occurs at the first edge with rst_n=1.
REQ-027 Reset mid-operation SHALL discard all buffered entries and any pending redirect.

Verification
REQ-028 Reset, RESET_PC=0, out_ready=1, memory holds 0x00A00093, 0x00400113 at 0,4 -> out_valid rises cycle 2 with out_pc=0/out_ins=0x00A00093, then out_pc=4/out_ins=0x00400113 next cycle; imem_addr steps 0,4,8,...
REQ-029 out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr stops at 8, out_pc held at 0; release -> 0,4,8 delivered in order, none lost or duplicated.
REQ-030 Full FIFO, out_ready=1 continuously -> one instruction accepted per cycle, count stays 2, PC advances by 4 each cycle.
REQ-031 redirect=1, redirect_pc=0x0000_0013 with 2 entries buffered -> out_valid=0 that cycle and next, imem_addr=0x10 next cycle, out_pc=0x10 two cycles later; stale PCs never presented.
REQ-032 PC forced to 0xFFFF_FFFC via redirect -> next fetch address 0x0000_0000, out_pc sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-033 rst_n pulled low between edges with count=2 -> out_valid=0 and imem_addr=RESET_PC immediately, before the next clk edge.
